// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// systolic_pkg : shared types, width defaults and overflow helper for the PE
// Rev 1.0
// ============================================================================
package systolic_pkg;

  typedef enum logic {
    PE_WS = 1'b0,
    PE_OS = 1'b1
  } pe_mode_e;

  localparam int PE_DATA_WIDTH = 16;
  localparam int PE_ACC_WIDTH  = 40;

  // Signed add overflows when both operands share a sign the result lacks.
  function automatic logic sat_add_ovf(input logic sa, input logic sb, input logic ss);
    return (sa == sb) && (ss != sa);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_sat_acc.sv
`default_nettype none
// ============================================================================
// pe_sat_acc : signed adder with overflow detect, optional clamp to range
// Rev 1.0
// ============================================================================
module pe_sat_acc
  import systolic_pkg::*;
#(
  parameter int ACC_WIDTH = PE_ACC_WIDTH,
  parameter bit SATURATE  = 1'b1
) (
  input  logic signed [ACC_WIDTH-1:0] a,
  input  logic signed [ACC_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0] sum,
  output logic                        ovf
);

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0] raw;

  always_comb begin
    raw = a + b;
    ovf = sat_add_ovf(a[ACC_WIDTH-1], b[ACC_WIDTH-1], raw[ACC_WIDTH-1]);
    sum = raw;
    if (SATURATE && ovf) sum = a[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
  end

endmodule
`default_nettype wire

// File: rtl/systolic_pe_cfg.sv
`default_nettype none
// ============================================================================
// systolic_pe_cfg : 3-stage WS/OS systolic PE with stall, clear and OS drain
// Rev 1.0
// ============================================================================
module systolic_pe_cfg
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = PE_DATA_WIDTH,
  parameter int ACC_WIDTH  = PE_ACC_WIDTH,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         clear,
  input  logic                         mode,
  input  logic signed [DATA_WIDTH-1:0] a_in,
  input  logic                         a_vld_in,
  input  logic signed [DATA_WIDTH-1:0] b_in,
  input  logic                         b_vld_in,
  input  logic                         load_w,
  input  logic signed [ACC_WIDTH-1:0]  psum_in,
  input  logic                         psum_vld_in,
  input  logic                         drain,
  output logic signed [DATA_WIDTH-1:0] a_out,
  output logic                         a_vld_out,
  output logic signed [DATA_WIDTH-1:0] b_out,
  output logic                         b_vld_out,
  output logic signed [ACC_WIDTH-1:0]  psum_out,
  output logic                         psum_vld_out,
  output logic                         ovf,
  output logic                         err
);

  localparam int PW = 2 * DATA_WIDTH;

  pe_mode_e                     mode_q;
  logic signed [DATA_WIDTH-1:0] w_q;
  logic signed [DATA_WIDTH-1:0] a_q, b_q;
  logic                         a_vld_q, b_vld_q, psum_vld1_q, drain1_q;
  logic signed [ACC_WIDTH-1:0]  psum1_q;
  logic signed [ACC_WIDTH-1:0]  prod_q, psum2_q;
  logic                         prod_vld_q, psum_vld2_q, drain2_q;
  logic signed [ACC_WIDTH-1:0]  acc_q, psum_q;
  logic                         psum_vld_q, ovf_q, err_q;

  logic signed [DATA_WIDTH-1:0] mul_b;
  logic                         mul_vld;
  logic signed [PW-1:0]         prod_full;
  logic signed [ACC_WIDTH-1:0]  add_a, add_b, add_sum;
  logic                         add_ovf;

  always_comb begin
    mul_b     = (mode_q == PE_OS) ? b_q : w_q;
    mul_vld   = (mode_q == PE_OS) ? (a_vld_q & b_vld_q) : a_vld_q;
    prod_full = PW'(a_q) * PW'(mul_b);
    // OS accumulates into acc; WS adds onto the incoming partial sum
    add_a     = (mode_q == PE_OS) ? acc_q : psum2_q;
    add_b     = prod_vld_q ? prod_q : '0;
  end

  pe_sat_acc #(
    .ACC_WIDTH (ACC_WIDTH),
    .SATURATE  (SATURATE)
  ) u_sat_acc (
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                w_q <= '0;
    else if (en && load_w)     w_q <= b_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0; b_q <= '0; psum1_q <= '0;
      a_vld_q <= 1'b0; b_vld_q <= 1'b0; psum_vld1_q <= 1'b0; drain1_q <= 1'b0;
    end else if (clear) begin
      a_vld_q <= 1'b0; b_vld_q <= 1'b0; psum_vld1_q <= 1'b0; drain1_q <= 1'b0;
    end else if (en) begin
      a_q <= a_in; b_q <= b_in; psum1_q <= psum_in;
      a_vld_q <= a_vld_in; b_vld_q <= b_vld_in; psum_vld1_q <= psum_vld_in; drain1_q <= drain;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0; psum2_q <= '0;
      prod_vld_q <= 1'b0; psum_vld2_q <= 1'b0; drain2_q <= 1'b0;
    end else if (clear) begin
      prod_vld_q <= 1'b0; psum_vld2_q <= 1'b0; drain2_q <= 1'b0;
    end else if (en) begin
      prod_q      <= ACC_WIDTH'(prod_full);
      prod_vld_q  <= mul_vld;
      psum2_q     <= psum1_q;
      psum_vld2_q <= psum_vld1_q;
      drain2_q    <= drain1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0; psum_q <= '0; psum_vld_q <= 1'b0;
      ovf_q <= 1'b0; err_q <= 1'b0; mode_q <= PE_WS;
    end else if (clear) begin
      acc_q <= '0; psum_q <= '0; psum_vld_q <= 1'b0;
      ovf_q <= 1'b0; err_q <= 1'b0; mode_q <= pe_mode_e'(mode);
    end else if (en) begin
      if (mode_q == PE_WS) begin
        if (prod_vld_q && psum_vld2_q) begin
          psum_q     <= add_sum;
          psum_vld_q <= 1'b1;
          if (add_ovf) ovf_q <= 1'b1;
        end else begin
          psum_q     <= psum2_q;
          psum_vld_q <= psum_vld2_q;
        end
      end else if (drain2_q) begin
        // Local drain beats a forwarded psum arriving in the same slot
        psum_q     <= add_sum;
        psum_vld_q <= 1'b1;
        acc_q      <= '0;
        if (add_ovf)     ovf_q <= 1'b1;
        if (psum_vld2_q) err_q <= 1'b1;
      end else begin
        if (prod_vld_q) begin
          acc_q <= add_sum;
          if (add_ovf) ovf_q <= 1'b1;
        end
        psum_q     <= psum2_q;
        psum_vld_q <= psum_vld2_q;
      end
    end
  end

  assign a_out        = a_q;
  assign a_vld_out    = a_vld_q;
  assign b_out        = b_q;
  assign b_vld_out    = b_vld_q;
  assign psum_out     = psum_q;
  assign psum_vld_out = psum_vld_q;
  assign ovf          = ovf_q;
  assign err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_pe_cfg.sv
`default_nettype none
// ============================================================================
// tb_systolic_pe_cfg : scoreboard bench for the WS/OS PE plus 33-bit sat/wrap
// Rev 1.0
// ============================================================================
module tb_systolic_pe_cfg;

  localparam int DW = 16;
  localparam int AW = 40;
  localparam int SW = 33;

  typedef struct {
    logic signed [AW-1:0] val;
    int                   due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, en, clear, mode;
  logic signed [DW-1:0] a_in, b_in;
  logic a_vld_in, b_vld_in, load_w, psum_vld_in, drain;
  logic signed [AW-1:0] psum_in;
  logic signed [SW-1:0] psum_in_n;

  logic signed [DW-1:0] a_out, b_out;
  logic a_vld_out, b_vld_out, psum_vld_out, ovf, err;
  logic signed [AW-1:0] psum_out;

  logic signed [DW-1:0] a_out_s, b_out_s, a_out_w, b_out_w;
  logic a_vld_out_s, b_vld_out_s, psum_vld_s, ovf_s, err_s;
  logic a_vld_out_w, b_vld_out_w, psum_vld_w, ovf_w, err_w;
  logic signed [SW-1:0] psum_out_s, psum_out_w;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ecnt   = 0;
  bit   en_last = 1'b0;

  assign psum_in_n = psum_in[SW-1:0];

  always #5 clk = ~clk;

  systolic_pe_cfg #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SATURATE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .mode(mode),
    .a_in(a_in), .a_vld_in(a_vld_in), .b_in(b_in), .b_vld_in(b_vld_in),
    .load_w(load_w), .psum_in(psum_in), .psum_vld_in(psum_vld_in), .drain(drain),
    .a_out(a_out), .a_vld_out(a_vld_out), .b_out(b_out), .b_vld_out(b_vld_out),
    .psum_out(psum_out), .psum_vld_out(psum_vld_out), .ovf(ovf), .err(err));

  systolic_pe_cfg #(.DATA_WIDTH(DW), .ACC_WIDTH(SW), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .mode(mode),
    .a_in(a_in), .a_vld_in(a_vld_in), .b_in(b_in), .b_vld_in(b_vld_in),
    .load_w(load_w), .psum_in(psum_in_n), .psum_vld_in(psum_vld_in), .drain(drain),
    .a_out(a_out_s), .a_vld_out(a_vld_out_s), .b_out(b_out_s), .b_vld_out(b_vld_out_s),
    .psum_out(psum_out_s), .psum_vld_out(psum_vld_s), .ovf(ovf_s), .err(err_s));

  systolic_pe_cfg #(.DATA_WIDTH(DW), .ACC_WIDTH(SW), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .mode(mode),
    .a_in(a_in), .a_vld_in(a_vld_in), .b_in(b_in), .b_vld_in(b_vld_in),
    .load_w(load_w), .psum_in(psum_in_n), .psum_vld_in(psum_vld_in), .drain(drain),
    .a_out(a_out_w), .a_vld_out(a_vld_out_w), .b_out(b_out_w), .b_vld_out(b_vld_out_w),
    .psum_out(psum_out_w), .psum_vld_out(psum_vld_w), .ovf(ovf_w), .err(err_w));

  task automatic idle();
    a_in = '0; a_vld_in = 1'b0; b_in = '0; b_vld_in = 1'b0; load_w = 1'b0;
    psum_in = '0; psum_vld_in = 1'b0; drain = 1'b0; clear = 1'b0;
  endtask

  // Expected output is due three enabled edges after the current drive.
  task automatic push(input logic signed [AW-1:0] v);
    exp_t e;
    e.val = v;
    e.due = ecnt + 3;
    sb.push_back(e);
  endtask

  // Pops the scoreboard whenever a fresh psum valid is produced.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rst_n && en_last && psum_vld_out) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_extra psum_out=%0d at en-cycle %0d, none expected", psum_out, ecnt);
      end else begin
        e = sb.pop_front();
        if (psum_out !== e.val || ecnt != e.due) begin
          errors++;
          $display("FAIL sb_psum got %0d at en-cycle %0d, expected %0d at en-cycle %0d",
                   psum_out, ecnt, e.val, e.due);
        end
      end
    end
    @(posedge clk);
    en_last = en;
    if (en) ecnt++;
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (psum_out !== '0 || psum_vld_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_psum got %0d/%0b want 0/0", psum_out, psum_vld_out);
    end
    checks++;
    if ({a_out, a_vld_out, b_out, b_vld_out, ovf, err} !== '0) begin
      errors++;
      $display("FAIL reset_fwd got a=%0d/%0b b=%0d/%0b ovf=%0b err=%0b want all 0",
               a_out, a_vld_out, b_out, b_vld_out, ovf, err);
    end
  endtask

  task automatic test_ws_basic();
    idle(); b_in = 16'sd3; load_w = 1'b1; tick();
    idle(); a_in = 16'sd5; a_vld_in = 1'b1; psum_in = 40'sd100; psum_vld_in = 1'b1;
    push(40'sd115); tick();
    checks++;
    if (a_out !== 16'sd5 || a_vld_out !== 1'b1) begin
      errors++;
      $display("FAIL ws_a_fwd got %0d/%0b want 5/1", a_out, a_vld_out);
    end
    idle(); psum_in = 40'sd42; psum_vld_in = 1'b1; push(40'sd42); tick();
    idle(); a_in = -16'sd7; a_vld_in = 1'b1; psum_in = 40'sd10; psum_vld_in = 1'b1;
    push(-40'sd11); tick();
    idle(); a_in = 16'sd9; a_vld_in = 1'b1; tick();
    idle(); b_in = -16'sd2; b_vld_in = 1'b1; tick();
    checks++;
    if (b_out !== -16'sd2 || b_vld_out !== 1'b1) begin
      errors++;
      $display("FAIL ws_b_fwd got %0d/%0b want -2/1", b_out, b_vld_out);
    end
    idle(); repeat (4) tick();
  endtask

  task automatic test_stall();
    logic signed [AW-1:0] snap_p;
    logic signed [DW-1:0] snap_a;
    logic                 snap_v;
    for (int i = 1; i <= 4; i++) begin
      if (i == 3) begin
        idle(); en = 1'b0;
        snap_p = psum_out; snap_a = a_out; snap_v = psum_vld_out;
        repeat (4) tick();
        checks++;
        if (psum_out !== snap_p || a_out !== snap_a || psum_vld_out !== snap_v) begin
          errors++;
          $display("FAIL stall_frozen got p=%0d a=%0d v=%0b want p=%0d a=%0d v=%0b",
                   psum_out, a_out, psum_vld_out, snap_p, snap_a, snap_v);
        end
        en = 1'b1;
      end
      idle(); a_in = DW'(i); a_vld_in = 1'b1; psum_in = AW'(10 * i); psum_vld_in = 1'b1;
      push(AW'(13 * i)); tick();
    end
    idle(); repeat (4) tick();
  endtask

  task automatic test_os();
    int pa[3] = '{2, -4, 7};
    int pb[3] = '{3, 5, 7};
    idle(); clear = 1'b1; mode = 1'b1; tick();
    idle(); mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle(); a_in = DW'(pa[i]); b_in = DW'(pb[i]); a_vld_in = 1'b1; b_vld_in = 1'b1; tick();
    end
    idle(); drain = 1'b1; push(40'sd35); tick();
    idle(); tick();
    idle(); drain = 1'b1; push(40'sd0); tick();
    idle(); drain = 1'b1; a_in = 16'sd3; b_in = 16'sd4; a_vld_in = 1'b1; b_vld_in = 1'b1;
    push(40'sd12); tick();
    idle(); psum_in = 40'sd9; psum_vld_in = 1'b1; push(40'sd9); tick();
    idle(); repeat (4) tick();
  endtask

  task automatic test_os_collision();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_pre got %0b want 0", err);
    end
    idle(); a_in = 16'sd2; b_in = 16'sd2; a_vld_in = 1'b1; b_vld_in = 1'b1; tick();
    idle(); tick();
    idle(); drain = 1'b1; psum_in = 40'sd77; psum_vld_in = 1'b1; push(40'sd4); tick();
    idle(); repeat (4) tick();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_collision got %0b want 1", err);
    end
  endtask

  task automatic test_clear();
    idle(); a_in = 16'sd5; b_in = 16'sd5; a_vld_in = 1'b1; b_vld_in = 1'b1; tick();
    idle(); psum_in = 40'sd55; psum_vld_in = 1'b1; push(40'sd55); tick();
    idle(); tick(); tick();
    en = 1'b0; clear = 1'b1; mode = 1'b1; tick();
    idle(); en = 1'b1; mode = 1'b0;
    checks++;
    if (psum_out !== '0 || psum_vld_out !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL clear_outputs got p=%0d v=%0b err=%0b want 0/0/0",
               psum_out, psum_vld_out, err);
    end
    idle(); drain = 1'b1; push(40'sd0); tick();
    idle(); repeat (4) tick();
    idle(); clear = 1'b1; mode = 1'b0; tick();
    idle(); a_in = 16'sd4; a_vld_in = 1'b1; psum_in = 40'sd1; psum_vld_in = 1'b1;
    push(40'sd13); tick();
    idle(); repeat (4) tick();
  endtask

  task automatic test_saturation();
    checks++;
    if (ovf_s !== 1'b0 || ovf_w !== 1'b0) begin
      errors++;
      $display("FAIL sat_ovf_pre got sat=%0b wrap=%0b want 0/0", ovf_s, ovf_w);
    end
    idle(); b_in = 16'sd32767; load_w = 1'b1; tick();
    idle(); a_in = 16'sd32767; a_vld_in = 1'b1; psum_in = 40'sd4294967295; psum_vld_in = 1'b1;
    push(40'sd5368643584); tick();
    idle(); tick(); tick();
    checks++;
    if (psum_out_s !== 33'h0FFFFFFFF || psum_vld_s !== 1'b1 || ovf_s !== 1'b1) begin
      errors++;
      $display("FAIL sat_clamp got %0h/%0b ovf=%0b want 0ffffffff/1 ovf=1",
               psum_out_s, psum_vld_s, ovf_s);
    end
    checks++;
    if (psum_out_w !== 33'd5368643584 || psum_vld_w !== 1'b1 || ovf_w !== 1'b1) begin
      errors++;
      $display("FAIL sat_wrap got %0h/%0b ovf=%0b want %0h/1 ovf=1",
               psum_out_w, psum_vld_w, ovf_w, 33'd5368643584);
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL wide_no_ovf got %0b want 0", ovf);
    end
    idle(); repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    idle(); clear = 1'b1; mode = 1'b1; tick();
    idle(); a_in = 16'sd3; b_in = 16'sd3; a_vld_in = 1'b1; b_vld_in = 1'b1; tick();
    idle(); a_in = 16'sd4; b_in = 16'sd4; a_vld_in = 1'b1; b_vld_in = 1'b1;
    psum_in = 40'sd8; psum_vld_in = 1'b1; tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({psum_out, psum_vld_out, a_out, a_vld_out, b_out, b_vld_out, ovf, err} !== '0) begin
      errors++;
      $display("FAIL reset_mid got p=%0d/%0b a=%0d/%0b b=%0d/%0b want all 0",
               psum_out, psum_vld_out, a_out, a_vld_out, b_out, b_vld_out);
    end
    idle(); mode = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    idle(); mode = 1'b1; b_in = 16'sd2; load_w = 1'b1; tick();
    idle(); mode = 1'b1; a_in = 16'sd5; a_vld_in = 1'b1; psum_in = 40'sd1; psum_vld_in = 1'b1;
    push(40'sd11); tick();
    idle(); repeat (5) tick();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; mode = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_ws_basic();
    test_stall();
    test_os();
    test_os_collision();
    test_clear();
    test_saturation();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
